// File: rtl/sd_spi_router_if.sv
`default_nettype none
// ============================================================================
//  Module      : sd_spi_router_if
//  Description : Bus bundle for sd_spi_router. It carries the core's SPI
//                master, the physical SD card pins, the per-slot virtual
//                sd_card chip selects and data, the HPS mount notifications,
//                and the route and activity status.
//                  slave  : router side. It drives miso, sd_*, vss, sel, act_*.
//                  master : environment side (core, cards, HPS, LEDs).
//  Revision    : 1.0  initial release
// ============================================================================
interface sd_spi_router_if #(
  parameter int CHANNELS = 2
);
  localparam int SEL_W = $clog2(CHANNELS + 1);

  // HPS image notifications, one bit per virtual slot
  logic [CHANNELS-1:0] img_mounted;
  logic [CHANNELS-1:0] img_present;

  // core SPI master
  logic ss;
  logic sck;
  logic mosi;
  logic miso;

  // physical card
  logic sd_cs;
  logic sd_sck;
  logic sd_mosi;
  logic sd_miso;

  // virtual cards
  logic [CHANNELS-1:0] vss;
  logic [CHANNELS-1:0] vmiso;

  // status
  logic [SEL_W-1:0] sel;
  logic act_phys;
  logic act_virt;

  modport slave (
    input  img_mounted, img_present,
    input  ss, sck, mosi,
    output miso,
    output sd_cs, sd_sck, sd_mosi,
    input  sd_miso,
    output vss,
    input  vmiso,
    output sel, act_phys, act_virt
  );

  modport master (
    output img_mounted, img_present,
    output ss, sck, mosi,
    input  miso,
    input  sd_cs, sd_sck, sd_mosi,
    output sd_miso,
    input  vss,
    output vmiso,
    input  sel, act_phys, act_virt
  );
endinterface
`default_nettype wire

// File: rtl/sd_spi_router.sv
`default_nettype none
// ============================================================================
//  Module      : sd_spi_router
//  Description : Routes the core's SPI master either to the physical SD card
//                (sel = 0) or to virtual image slot sel-1. A mount or unmount
//                is first latched as a pending request and then applied to
//                sel. Activity timers for the physical and virtual paths
//                drive the LED indicators.
//  Ports       : clock        system clock
//                reset        synchronous, active-low
//                bus.slave    SPI, card, image and status signals
//                             (see sd_spi_router_if)
//  Parameters  : CHANNELS     virtual slots, 1..8
//                TIMEOUT      activity hold time in clocks
//                IDLE_CYCLES  ss-high cycles required before a switch
//  Config      : SD_ROUTER_IDLE_SWITCH_EN
//                  defined   - switch only after IDLE_CYCLES of ss high
//                  undefined - apply pending request on the next cycle
//  Revision    : 1.0  initial release
// ============================================================================
module sd_spi_router #(
  parameter int CHANNELS    = 2,
  parameter int TIMEOUT     = 1000000,
  parameter int IDLE_CYCLES = 8
) (
  input  wire logic         clock,
  input  wire logic         reset,
  sd_spi_router_if.slave    bus
);

  localparam int SEL_W = $clog2(CHANNELS + 1);
  localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

  // --------------------------------------------------------------------------
  // Route state
  // --------------------------------------------------------------------------
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] pend_sel;
  logic             pend_valid;
  logic             idle_ok;
  logic             apply;

  // --------------------------------------------------------------------------
  // Mount decode: only the lowest set img_mounted bit is considered
  // --------------------------------------------------------------------------
  logic             mnt_hit;
  logic             mnt_present;
  logic [SEL_W-1:0] mnt_slot;

  always_comb begin
    mnt_hit     = 1'b0;
    mnt_present = 1'b0;
    mnt_slot    = '0;
    // Scan downwards so the lowest set bit is the one that sticks
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (bus.img_mounted[k]) begin
        mnt_hit     = 1'b1;
        mnt_present = bus.img_present[k];
        mnt_slot    = SEL_W'(k + 1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Idle qualification
  // --------------------------------------------------------------------------
`ifdef SD_ROUTER_IDLE_SWITCH_EN
  localparam int IDLE_W = (IDLE_CYCLES < 1) ? 1 : $clog2(IDLE_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);

  logic [IDLE_W-1:0] idle_cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (!bus.ss) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign idle_ok = (idle_cnt == IDLE_MAX);
`else
  // Legacy behaviour: no idle window. IDLE_CYCLES is kept only so the
  // parameter list is identical in both builds; the expression is always true.
  assign idle_ok = (IDLE_CYCLES >= 0);
`endif

  assign apply = pend_valid & idle_ok;

  // --------------------------------------------------------------------------
  // Pending request and route register.
  // The mount branch comes after the apply branch, so a mount arriving in the
  // same cycle as an apply re-arms pend_* for a later window.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      sel        <= '0;
      pend_sel   <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (apply) begin
        sel        <= pend_sel;
        pend_valid <= 1'b0;
      end
      if (mnt_hit) begin
        if (mnt_present) begin
          pend_sel   <= mnt_slot;
          pend_valid <= 1'b1;
        end else if ((sel == mnt_slot) || (pend_sel == mnt_slot)) begin
          // Unmount of the active or pending slot: fall back to physical
          pend_sel   <= '0;
          pend_valid <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Combinational routing from the registered sel
  // --------------------------------------------------------------------------
  logic phys_sel;
  logic miso_rt;

  assign phys_sel    = (sel == '0);
  assign bus.sd_cs   = bus.ss | ~phys_sel;
  assign bus.sd_sck  = bus.sck & phys_sel;
  assign bus.sd_mosi = bus.mosi & phys_sel;

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_vss
      assign bus.vss[k] = bus.ss | (sel != SEL_W'(k + 1));
    end
  endgenerate

  // The loop form keeps every index in range even for an illegal sel value
  always_comb begin
    miso_rt = bus.sd_miso;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k + 1)) begin
        miso_rt = bus.vmiso[k];
      end
    end
  end

  assign bus.miso = miso_rt;
  assign bus.sel  = sel;

  // --------------------------------------------------------------------------
  // Activity detection.
  // mosi and the routed miso are sampled once. Each sample is then compared
  // with a one-cycle delayed copy, so an input change in cycle n clears the
  // timer at the end of cycle n+1 and act_* rises in cycle n+2.
  // --------------------------------------------------------------------------
  logic             mosi_q, mosi_d;
  logic             miso_q, miso_d;
  logic             spi_edge;
  logic [TMR_W-1:0] tmr_p;
  logic [TMR_W-1:0] tmr_v;

  always_ff @(posedge clock) begin
    if (!reset) begin
      mosi_q <= 1'b0;
      mosi_d <= 1'b0;
      miso_q <= 1'b0;
      miso_d <= 1'b0;
    end else begin
      mosi_q <= bus.mosi;
      mosi_d <= mosi_q;
      miso_q <= miso_rt;
      miso_d <= miso_q;
    end
  end

  assign spi_edge = (mosi_q ^ mosi_d) | (miso_q ^ miso_d);

  always_ff @(posedge clock) begin
    if (!reset) begin
      tmr_p <= TMR_MAX;
      tmr_v <= TMR_MAX;
    end else begin
      if (spi_edge && phys_sel) begin
        tmr_p <= '0;
      end else if (tmr_p != TMR_MAX) begin
        tmr_p <= tmr_p + 1'b1;
      end

      if (spi_edge && !phys_sel) begin
        tmr_v <= '0;
      end else if (tmr_v != TMR_MAX) begin
        tmr_v <= tmr_v + 1'b1;
      end
    end
  end

  assign bus.act_phys = (tmr_p < TMR_MAX);
  assign bus.act_virt = (tmr_v < TMR_MAX);

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_spi_router
//  Description : Directed testbench for sd_spi_router with CHANNELS=2,
//                TIMEOUT=16 and IDLE_CYCLES=8. Expected switch timing follows
//                SD_ROUTER_IDLE_SWITCH_EN, so the bench can be built with the
//                same macro setting as the design.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sd_spi_router;

  localparam int CHANNELS    = 2;
  localparam int TIMEOUT     = 16;
  localparam int IDLE_CYCLES = 8;

  logic clock;
  logic reset;

  int n_checks;
  int n_pass;

  sd_spi_router_if #(.CHANNELS(CHANNELS)) bus ();

  sd_spi_router #(
    .CHANNELS    (CHANNELS),
    .TIMEOUT     (TIMEOUT),
    .IDLE_CYCLES (IDLE_CYCLES)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    reset           = 1'b0;
    bus.ss          = 1'b1;
    bus.sck         = 1'b0;
    bus.mosi        = 1'b0;
    bus.sd_miso     = 1'b0;
    bus.vmiso       = '0;
    bus.img_mounted = '0;
    bus.img_present = '0;

    // ---------------- reset ----------------
    tick(2);
    check("rst_sel",      32'(bus.sel),      32'd0);
    check("rst_act_phys", 32'(bus.act_phys), 32'd0);
    check("rst_act_virt", 32'(bus.act_virt), 32'd0);
    check("rst_vss",      32'(bus.vss),      32'h3);
    check("rst_sd_cs_hi", 32'(bus.sd_cs),    32'd1);
    bus.ss = 1'b0;
    #1;
    check("rst_sd_cs_lo", 32'(bus.sd_cs),    32'd0);
    check("rst_vss_sslo", 32'(bus.vss),      32'h3);
    bus.ss = 1'b1;
    reset  = 1'b1;
    tick(1);

    // ---------------- activity (physical path) ----------------
    bus.mosi = 1'b1;               // change in cycle n
    tick(1);
    check("act_n1",       32'(bus.act_phys), 32'd0);
    tick(1);
    check("act_n2",       32'(bus.act_phys), 32'd1);
    check("act_virt_idle", 32'(bus.act_virt), 32'd0);
    tick(15);
    check("act_last",     32'(bus.act_phys), 32'd1);
    tick(1);
    check("act_expired",  32'(bus.act_phys), 32'd0);
    check("act_virt_end", 32'(bus.act_virt), 32'd0);

    // ---------------- mount slot 1 with ss low ----------------
    bus.ss = 1'b0;
    tick(3);
    bus.img_mounted = 2'b10;
    bus.img_present = 2'b10;
    tick(1);                       // pending latched here
    bus.img_mounted = 2'b00;
`ifdef SD_ROUTER_IDLE_SWITCH_EN
    tick(3);
    check("defer_sslo",   32'(bus.sel),      32'd0);
    bus.ss = 1'b1;                 // rise
    tick(8);
    check("defer_8",      32'(bus.sel),      32'd0);
    tick(1);
    check("defer_9",      32'(bus.sel),      32'd2);
`else
    check("legacy_1",     32'(bus.sel),      32'd0);
    tick(1);
    check("legacy_2",     32'(bus.sel),      32'd2);
    bus.ss = 1'b1;
`endif
    #1;
    check("v1_vss_sshi",  32'(bus.vss),      32'h3);
    check("v1_sd_cs_hi",  32'(bus.sd_cs),    32'd1);
    bus.ss  = 1'b0;
    bus.sck = 1'b1;
    #1;
    check("v1_vss_sslo",  32'(bus.vss),      32'h1);
    check("v1_sd_cs_lo",  32'(bus.sd_cs),    32'd1);
    check("v1_sd_sck",    32'(bus.sd_sck),   32'd0);
    check("v1_sd_mosi",   32'(bus.sd_mosi),  32'd0);
    bus.vmiso = 2'b10;
    #1;
    check("v1_miso_1",    32'(bus.miso),     32'd1);
    bus.vmiso = 2'b01;
    #1;
    check("v1_miso_0",    32'(bus.miso),     32'd0);
    bus.vmiso = 2'b00;
    bus.sck   = 1'b0;
    bus.ss    = 1'b1;
    tick(10);

    // ---------------- simultaneous mount, bus idle ----------------
    bus.img_mounted = 2'b11;
    bus.img_present = 2'b11;
    tick(1);
    bus.img_mounted = 2'b00;
    check("simul_1",      32'(bus.sel),      32'd2);
    tick(1);
    check("simul_2",      32'(bus.sel),      32'd1);

    // ---------------- unmount of the inactive slot keeps route ----------------
    bus.img_mounted = 2'b10;
    bus.img_present = 2'b00;
    tick(1);
    bus.img_mounted = 2'b00;
    tick(3);
    check("unmnt_other",  32'(bus.sel),      32'd1);

    // ---------------- unmount of the active slot falls back ----------------
    bus.img_mounted = 2'b01;
    bus.img_present = 2'b00;
    tick(1);
    bus.img_mounted = 2'b00;
    tick(1);
    check("unmnt_active", 32'(bus.sel),      32'd0);
    bus.ss      = 1'b0;
    bus.sck     = 1'b1;
    bus.mosi    = 1'b1;
    bus.sd_miso = 1'b1;
    #1;
    check("phys_sd_cs",   32'(bus.sd_cs),    32'd0);
    check("phys_sd_sck",  32'(bus.sd_sck),   32'd1);
    check("phys_sd_mosi", 32'(bus.sd_mosi),  32'd1);
    check("phys_miso",    32'(bus.miso),     32'd1);
    check("phys_vss",     32'(bus.vss),      32'h3);
    bus.mosi = 1'b0;
    #1;
    check("phys_mosi_0",  32'(bus.sd_mosi),  32'd0);
    bus.sck     = 1'b0;
    bus.sd_miso = 1'b0;

    // ---------------- reset mid-transfer discards pending ----------------
    bus.img_mounted = 2'b10;
    bus.img_present = 2'b10;
    tick(1);
    bus.img_mounted = 2'b00;
    reset = 1'b0;
    tick(1);
    check("midrst_sel",   32'(bus.sel),      32'd0);
    check("midrst_act_v", 32'(bus.act_virt), 32'd0);
    check("midrst_act_p", 32'(bus.act_phys), 32'd0);
    reset  = 1'b1;
    bus.ss = 1'b1;
    tick(12);
    check("midrst_drop",  32'(bus.sel),      32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
